// File: rtl/coef_updater_pkg.sv
// coef_updater_pkg: shared Q10.10 constants, FSM state type and clog2 helper
package coef_updater_pkg;
  localparam int FRAC_BITS = 10;
  localparam int DATA_W = 20;
  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; (1 << i) < v; i++) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/coef_updater_grad_accum.sv
// grad_accum: batch gradient accumulators sumE and sumEX (clk, reset, clear, en, x, e -> sum_e, sum_ex)
module grad_accum
  import coef_updater_pkg::*;
#(
  parameter int N_SAMPLES = 64,
  localparam int SE_W = DATA_W + clog2(N_SAMPLES) + 1,
  localparam int SEX_W = 2 * DATA_W + clog2(N_SAMPLES) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] e,
  output logic signed [SE_W-1:0]   sum_e,
  output logic signed [SEX_W-1:0]  sum_ex
);
  logic signed [2*DATA_W-1:0] prod;
  assign prod = e * x;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum_e  <= '0;
      sum_ex <= '0;
    end else if (en) begin
      sum_e  <= sum_e + {{(SE_W-DATA_W){e[DATA_W-1]}}, e};
      sum_ex <= sum_ex + {{(SEX_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end
endmodule

// File: rtl/coef_updater.sv
// coef_updater: batch gradient descent on B0/B1 from the E/X stream
// Ports: clk, reset (sync, active-high), start, en/X/E sample input with ready,
// B0/B1 coefficients (Q10.10), epoch_done pulse on each update, done after EPOCHS.
module coef_updater
  import coef_updater_pkg::*;
#(
  parameter int N_SAMPLES = 64,
  parameter int EPOCHS = 16,
  parameter int ALPHA_SHIFT = 6,
  parameter logic [DATA_W-1:0] B0_INIT = 20'h00000,
  parameter logic [DATA_W-1:0] B1_INIT = 20'h00000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] X,
  input  logic signed [DATA_W-1:0] E,
  output logic                     ready,
  output logic [DATA_W-1:0]        B0,
  output logic [DATA_W-1:0]        B1,
  output logic                     epoch_done,
  output logic                     done
);
  localparam int CW = clog2(N_SAMPLES);
  localparam int EW = clog2(EPOCHS + 1);
  localparam int SE_W = DATA_W + CW + 1;
  localparam int SEX_W = 2 * DATA_W + CW + 1;
  state_t state, nxt;
  logic [CW-1:0] sample_cnt;
  logic [EW-1:0] epoch_cnt;
  logic take, clear, begin_run, last_sample, last_epoch;
  logic signed [SE_W-1:0] sum_e, sh_e;
  logic signed [SEX_W-1:0] sum_ex, sh_ex;
  assign ready = state == ACCUM;
  assign done = state == DONE;
  assign take = ready && en;
  assign begin_run = (state == IDLE || state == DONE) && start;
  assign last_sample = sample_cnt == CW'(N_SAMPLES - 1);
  assign last_epoch = epoch_cnt == EW'(EPOCHS - 1);
  // sumEX is Q20.20, so the extra FRAC_BITS shift brings it back to Q10.10
  assign sh_e = sum_e >>> ALPHA_SHIFT;
  assign sh_ex = sum_ex >>> (FRAC_BITS + ALPHA_SHIFT);
  always_comb begin
    nxt = state;
    clear = begin_run;
    case (state)
      IDLE, DONE: nxt = start ? ACCUM : state;
      ACCUM: nxt = (take && last_sample) ? UPDATE : ACCUM;
      UPDATE: begin
        nxt = last_epoch ? DONE : ACCUM;
        clear = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end
  grad_accum #(.N_SAMPLES(N_SAMPLES)) u_accum (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .en(take),
    .x(X),
    .e(E),
    .sum_e(sum_e),
    .sum_ex(sum_ex)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sample_cnt <= '0;
      epoch_cnt <= '0;
      B0 <= B0_INIT;
      B1 <= B1_INIT;
      epoch_done <= 1'b0;
    end else begin
      state <= nxt;
      epoch_done <= state == UPDATE;
      if (clear) sample_cnt <= '0;
      else if (take) sample_cnt <= sample_cnt + 1'b1;
      if (begin_run) epoch_cnt <= '0;
      else if (state == UPDATE && !last_epoch) epoch_cnt <= epoch_cnt + 1'b1;
      if (state == UPDATE) begin
        B0 <= B0 + sh_e[DATA_W-1:0];
        B1 <= B1 + sh_ex[DATA_W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_coef_updater.sv
// tb_coef_updater: directed vector bench for coef_updater (one- and two-epoch instances)
module tb_coef_updater;
  typedef struct {
    logic [19:0] e;
    logic [19:0] x;
    logic [19:0] b0;
    logic [19:0] b1;
  } vec_t;
  logic clk = 1'b0;
  logic rst1, rst2, st1, st2, en;
  logic [19:0] X, E;
  logic rdy1, ed1, dn1, rdy2, ed2, dn2;
  logic [19:0] b0_1, b1_1, b0_2, b1_2;
  int checks = 0;
  int failures = 0;
  int ed_cnt1 = 0;
  int ed_cnt2 = 0;
  int e0;
  vec_t vecs[5];
  int pat[7];
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ed1) ed_cnt1++;
    if (ed2) ed_cnt2++;
  end
  coef_updater #(.N_SAMPLES(4), .EPOCHS(1), .ALPHA_SHIFT(2)) u1 (
    .clk(clk), .reset(rst1), .start(st1), .en(en), .X(X), .E(E),
    .ready(rdy1), .B0(b0_1), .B1(b1_1), .epoch_done(ed1), .done(dn1)
  );
  coef_updater #(.N_SAMPLES(4), .EPOCHS(2), .ALPHA_SHIFT(2)) u2 (
    .clk(clk), .reset(rst2), .start(st2), .en(en), .X(X), .E(E),
    .ready(rdy2), .B0(b0_2), .B1(b1_2), .epoch_done(ed2), .done(dn2)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, x);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    vecs[0] = '{20'h00400, 20'h00800, 20'h00400, 20'h00800};
    vecs[1] = '{20'hFFE00, 20'h00400, 20'hFFE00, 20'hFFE00};
    vecs[2] = '{20'h00100, 20'hFFC00, 20'h00100, 20'hFFF00};
    vecs[3] = '{20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'hFFC00};
    vecs[4] = '{20'h80000, 20'h80000, 20'h80000, 20'h00000};
    pat = '{1, 0, 0, 1, 0, 1, 1};
    rst1 = 1; rst2 = 1; st1 = 0; st2 = 0; en = 0; X = 0; E = 0;
    tick; tick;
    rst2 = 0;
    chk("rst_ready", {31'd0, rdy2}, 0);
    chk("rst_b0", {12'd0, b0_2}, 0);
    chk("rst_b1", {12'd0, b1_2}, 0);
    chk("rst_done", {31'd0, dn2}, 0);
    chk("rst_epoch_done", {31'd0, ed2}, 0);
    foreach (vecs[i]) begin
      rst1 = 1; tick; rst1 = 0;
      chk($sformatf("v%0d_rst_b0", i), {12'd0, b0_1}, 0);
      chk($sformatf("v%0d_idle_ready", i), {31'd0, rdy1}, 0);
      st1 = 1; tick; st1 = 0;
      chk($sformatf("v%0d_accum_ready", i), {31'd0, rdy1}, 1);
      e0 = ed_cnt1;
      for (int k = 0; k < 4; k++) begin
        en = 1; E = vecs[i].e; X = vecs[i].x; tick;
      end
      en = 0;
      chk($sformatf("v%0d_update_ready", i), {31'd0, rdy1}, 0);
      chk($sformatf("v%0d_t1_epoch_done", i), {31'd0, ed1}, 0);
      tick;
      chk($sformatf("v%0d_t2_epoch_done", i), {31'd0, ed1}, 1);
      chk($sformatf("v%0d_b0", i), {12'd0, b0_1}, {12'd0, vecs[i].b0});
      chk($sformatf("v%0d_b1", i), {12'd0, b1_1}, {12'd0, vecs[i].b1});
      chk($sformatf("v%0d_done", i), {31'd0, dn1}, 1);
      tick;
      chk($sformatf("v%0d_pulse_end", i), {31'd0, ed1}, 0);
      chk($sformatf("v%0d_done_hold", i), {31'd0, dn1}, 1);
      chk($sformatf("v%0d_pulses", i), ed_cnt1 - e0, 1);
    end
    st2 = 1; tick; st2 = 0;
    e0 = ed_cnt2;
    E = 20'h00400; X = 20'h00800;
    foreach (pat[j]) begin
      en = pat[j][0]; tick;
    end
    tick;
    en = 0;
    chk("gap_epoch_done", {31'd0, ed2}, 1);
    chk("gap_b0", {12'd0, b0_2}, 20'h00400);
    chk("gap_b1", {12'd0, b1_2}, 20'h00800);
    chk("gap_ready_with_pulse", {31'd0, rdy2}, 1);
    chk("gap_not_done", {31'd0, dn2}, 0);
    en = 1; tick; tick; en = 0;
    st2 = 1; tick; st2 = 0;
    en = 1; tick; tick; en = 0;
    chk("e2_update_not_done", {31'd0, dn2}, 0);
    tick;
    chk("e2_b0", {12'd0, b0_2}, 20'h00800);
    chk("e2_b1", {12'd0, b1_2}, 20'h01000);
    chk("e2_done", {31'd0, dn2}, 1);
    chk("e2_ready", {31'd0, rdy2}, 0);
    tick;
    chk("e2_two_pulses", ed_cnt2 - e0, 2);
    en = 1; tick; tick; en = 0;
    chk("done_hold_b0", {12'd0, b0_2}, 20'h00800);
    st2 = 1; tick; st2 = 0;
    chk("restart_done_low", {31'd0, dn2}, 0);
    chk("restart_ready", {31'd0, rdy2}, 1);
    en = 1; tick; tick; tick; tick; en = 0;
    tick;
    chk("e3_b0", {12'd0, b0_2}, 20'h00C00);
    chk("e3_b1", {12'd0, b1_2}, 20'h01800);
    chk("e3_not_done", {31'd0, dn2}, 0);
    en = 1; tick; tick; en = 0;
    rst2 = 1; tick; rst2 = 0;
    chk("midrst_b0", {12'd0, b0_2}, 0);
    chk("midrst_b1", {12'd0, b1_2}, 0);
    chk("midrst_ready", {31'd0, rdy2}, 0);
    chk("midrst_done", {31'd0, dn2}, 0);
    en = 1; tick; tick; tick; en = 0;
    chk("idle_en_b0", {12'd0, b0_2}, 0);
    chk("idle_en_ready", {31'd0, rdy2}, 0);
    chk("idle_en_pulse", {31'd0, ed2}, 0);
    st2 = 1; tick; st2 = 0;
    en = 1; tick; tick; tick; tick; en = 0;
    tick;
    chk("post_rst_b0", {12'd0, b0_2}, 20'h00400);
    chk("post_rst_b1", {12'd0, b1_2}, 20'h00800);
    chk("post_rst_not_done", {31'd0, dn2}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coef_updater.md
Name: coef_updater

Overview:
- Consumes the per-sample error stream E = Y - (B0 + B1*X) produced by the error-checking stage, together with the matching X.
- Accumulates the batch gradient over N_SAMPLES samples, then applies one gradient-descent step to B0/B1.
- Feeds the updated coefficients back to the error-checking stage and pulses epoch_done so the controller can re-init that stage (initEC) for the next pass.
- Repeats for EPOCHS passes, then raises done.

Parameters:
- N_SAMPLES, 64: samples per epoch (batch size); must be >= 2.
- EPOCHS, 16: number of update steps before done.
- ALPHA_SHIFT, 6: learning rate, alpha = 2^-ALPHA_SHIFT (arithmetic right shift).
- B0_INIT, 20'h00000: reset value of B0, Q10.10.
- B1_INIT, 20'h00000: reset value of B1, Q10.10.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins training from IDLE or DONE.
- en  input  1  sample valid; the sample is consumed only when en && ready.
- X  input  20  feature sample, signed Q10.10.
- E  input  20  error sample, signed Q10.10 (two's complement).
- ready  output  1  block is accepting samples.
- B0  output  20  intercept coefficient, Q10.10.
- B1  output  20  slope coefficient, Q10.10.
- epoch_done  output  1  one-cycle pulse when B0/B1 take new values.
- done  output  1  all epochs complete; held high.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, reset). Reset has priority over every other input.
- Reset values: B0=B0_INIT, B1=B1_INIT, ready=0, epoch_done=0, done=0, state IDLE, all counters and accumulators 0.
- Internal registers:
  - sumE: signed, 20+clog2(N_SAMPLES)+1 bits.
  - sumEX: signed, 40+clog2(N_SAMPLES)+1 bits.
  - sample_cnt, epoch_cnt.
- IDLE:
  - ready=0; en ignored.
  - start -> ACCUM; clear sumE, sumEX, sample_cnt, epoch_cnt; ready=1 from the next cycle.
- ACCUM:
  - ready=1.
  - On en: sumE += sext(E); sumEX += signed(E)*signed(X) (full 40-bit product, Q20.20); sample_cnt++.
  - en=0 cycles are gaps and change nothing.
  - The en cycle with sample_cnt==N_SAMPLES-1 is the last accepted sample -> UPDATE; ready=0 the next cycle.
  - start is ignored in this state.
- UPDATE (exactly 1 cycle):
  - ready=0; en ignored.
  - B0 <= B0 + (sumE >>> ALPHA_SHIFT)[19:0].
  - B1 <= B1 + (sumEX >>> (10+ALPHA_SHIFT))[19:0].
  - Both additions wrap modulo 2^20; no saturation.
  - epoch_done=1 in the cycle after UPDATE, coincident with the new B0/B1 values.
  - If epoch_cnt==EPOCHS-1 -> DONE. Otherwise epoch_cnt++, clear accumulators and sample_cnt, -> ACCUM (ready=1 in the same cycle epoch_done is high).
- DONE:
  - done=1, ready=0; B0/B1 hold.
  - start -> ACCUM with the current B0/B1 retained (continued training); done drops the next cycle, epoch_cnt cleared.
  - Only reset restores B0_INIT/B1_INIT.
- Latency: last sample accepted at cycle t -> new B0/B1 and epoch_done at t+2.
- Reset mid-ACCUM or mid-UPDATE: partial sums are discarded and no coefficient update occurs.

Decomposition:
- Shared package:
  - Q10.10 constants: FRAC_BITS=10, DATA_W=20.
  - State enum: IDLE, ACCUM, UPDATE, DONE.
  - clog2 helper.
- One sub-module, grad_accum: holds sumE/sumEX, clear/en inputs, and the signed multiply-accumulate.
- The FSM and coefficient registers stay in coef_updater.

Test Plan:
- N_SAMPLES=4, ALPHA_SHIFT=2, EPOCHS=1; 4x (E=20'h00400, X=20'h00800), then start -> B0=20'h00400, B1=20'h00800, one epoch_done pulse 2 cycles after the last sample, done=1.
- Same parameters, 4x (E=20'hFFE00 (-0.5), X=20'h00400) -> B0=20'hFFE00, B1=20'hFFE00 (sign extension correct).
- EPOCHS=2, same constant stimulus as the first case over both epochs -> B0=20'h00800, B1=20'h01000, exactly two epoch_done pulses, done after the second.
- en toggled 1,0,0,1,0,1,1 -> exactly 4 samples counted; sums match the first case. en during UPDATE/IDLE is not counted.
- Reset after 2 accepted samples -> B0=B1=0, ready=0, IDLE. Later en pulses without start leave all outputs unchanged.
- start pulsed during ACCUM is ignored. start in DONE continues from current B0/B1; a third epoch gives B0=20'h00C00.
